// File: rtl/id_pkg.sv
// ID-stage shared definitions: control bundle layout, instruction field positions, XZR helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package id_pkg;

    // Control bundle layout, MSB first, as driven by the parent's Control decoder.
    localparam int CTRL_W      = 12;
    localparam int C_REG2LOC   = 11;
    localparam int C_ALUSRC    = 10;
    localparam int C_MEM2REG   = 9;
    localparam int C_REGWRITE  = 8;
    localparam int C_MEMREAD   = 7;
    localparam int C_MEMWRITE  = 6;
    localparam int C_BRANCH    = 5;
    localparam int C_UNCOND    = 4;
    localparam int C_ALUOP_LSB = 0;
    localparam int ALUOP_W     = 4;

    // Register-address fields inside the instruction word; each field is 5 bits.
    localparam int RD_LSB  = 0;
    localparam int RM_LSB  = 5;
    localparam int RN_LSB  = 16;
    localparam int FIELD_W = 5;

    // What the ID/EX register does on the coming edge, highest priority first.
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_NORMAL = 2'd3
    } idex_act_e;

    // Index of the zero register: the highest address for a given address width.
    function automatic int unsigned xzr(input int unsigned ra_w);
        return (32'd1 << ra_w) - 32'd1;
    endfunction

endpackage

// File: rtl/id_stage_hz_regfile.sv
// Register file with two combinational read ports and one write port; XZR reads as zero.
// Latency: reads 0 cycles (same-cycle write data bypassed to readers), write lands at the edge.
// Backpressure: none; the write port is always accepted.
module regfile_bypass #(
    parameter int DATA_W = 64,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RA_W-1:0]   rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [RA_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);
    import id_pkg::*;

    localparam int              NREG = 1 << RA_W;
    localparam logic [RA_W-1:0] XZR  = RA_W'(xzr(RA_W));

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_live;

    // A write to XZR is dropped, so it can neither store nor bypass.
    assign wr_live = wr_en && (wr_addr != XZR);

    // Storage: cleared on reset, written at the edge.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A: XZR forced to zero, then same-cycle write bypass, then storage.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == XZR) begin
            rd_data_a = '0;
        end else if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == XZR) begin
            rd_data_b = '0;
        end else if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// ID stage: operand fetch, load-use hazard detection and the ID/EX pipeline register.
// Latency: 1 cycle ID->EX; a load-use hazard inserts exactly one bubble.
// Backpressure: ex_stall holds ID/EX and raises stall_if; flush squashes and never stalls.
module id_stage_hz #(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int RA_W    = 5,
    parameter int CTRL_W  = id_pkg::CTRL_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetl,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic [PC_W-1:0]    id_pc,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               wb_regwrite,
    input  logic [RA_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               stall_if,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [RA_W-1:0]    ex_rd,
    output logic [RA_W-1:0]    ex_rm,
    output logic [RA_W-1:0]    ex_rn,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [PC_W-1:0]    ex_pc,
    output logic [CNT_W-1:0]   stall_count
);
    import id_pkg::*;

    localparam logic [RA_W-1:0] XZR = RA_W'(xzr(RA_W));

    logic [RA_W-1:0]   id_rd;
    logic [RA_W-1:0]   id_rm;
    logic [RA_W-1:0]   id_rn;
    logic              use_rm;
    logic              use_rn;
    logic              hazard;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    idex_act_e         act;
    logic              unused_instr;

    // Register-address extraction; fields are zero-extended for wider register files.
    assign id_rd = RA_W'(id_instr[RD_LSB +: FIELD_W]);
    assign id_rm = RA_W'(id_instr[RM_LSB +: FIELD_W]);
    assign id_rn = id_ctrl[C_REG2LOC] ? id_rd : RA_W'(id_instr[RN_LSB +: FIELD_W]);

    // Opcode and shamt bits are decoded by the parent, not here.
    assign unused_instr = ^{id_instr[INSTR_W-1:RN_LSB+FIELD_W],
                            id_instr[RN_LSB-1:RM_LSB+FIELD_W]};

    // Which source addresses the ID instruction actually reads.
    assign use_rm = !id_ctrl[C_UNCOND];
    assign use_rn = !id_ctrl[C_UNCOND] && (id_ctrl[C_REG2LOC] || !id_ctrl[C_ALUSRC]);

    regfile_bypass #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_rf (
        .clk       (clk),
        .resetl    (resetl),
        .wr_en     (wb_regwrite),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data),
        .rd_addr_a (id_rm),
        .rd_data_a (rf_a),
        .rd_addr_b (id_rn),
        .rd_data_b (rf_b)
    );

    // Load-use: the load in EX has not produced its data yet, so a dependent ID must wait.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_valid && ex_ctrl[C_MEMREAD] && (ex_rd != XZR)) begin
            hazard = (use_rm && (ex_rd == id_rm)) || (use_rn && (ex_rd == id_rn));
        end
    end

    // Edge action and IF/ID stall; flush wins because the dependent instruction is squashed.
    always_comb begin
        act = ACT_NORMAL;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (ex_stall) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_BUBBLE;
        end
        stall_if = (act == ACT_HOLD) || (act == ACT_BUBBLE);
    end

    // Valid and control: cleared by flush/bubble so no side effects leak into EX.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    ex_valid <= 1'b0;
                    ex_ctrl  <= '0;
                end
                ACT_HOLD: begin
                    ex_valid <= ex_valid;
                    ex_ctrl  <= ex_ctrl;
                end
                default: begin
                    ex_valid <= id_valid;
                    ex_ctrl  <= id_valid ? id_ctrl : '0;
                end
            endcase
        end
    end

    // Data fields only move on a normal advance; killed slots keep stale but harmless data.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            ex_rd  <= '0;
            ex_rm  <= '0;
            ex_rn  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            ex_imm <= '0;
            ex_pc  <= '0;
        end else if (act == ACT_NORMAL) begin
            ex_rd  <= id_rd;
            ex_rm  <= id_rm;
            ex_rn  <= id_rn;
            ex_a   <= rf_a;
            ex_b   <= rf_b;
            ex_imm <= id_imm;
            ex_pc  <= id_pc;
        end
    end

    // Bubble counter, saturating at all ones.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            stall_count <= '0;
        end else if ((act == ACT_BUBBLE) && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz with a queue of expected ID/EX contents.
// Latency: expectations are pushed at drive time and popped one edge later.
// Backpressure: exercises flush, ex_stall and load-use bubbles.
module tb_id_stage_hz;

    localparam int DATA_W  = 64;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int RA_W    = 5;
    localparam int CTRL_W  = 12;
    localparam int CNT_W   = 2;

    // Control bundles: ADD (reg-reg), LDUR (load, alusrc), ADDI (alusrc).
    localparam logic [11:0] C_ADD  = 12'h102;
    localparam logic [11:0] C_LDUR = 12'h782;
    localparam logic [11:0] C_ADDI = 12'h502;

    logic               clk;
    logic               resetl;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;
    logic [CTRL_W-1:0]  id_ctrl;
    logic [DATA_W-1:0]  id_imm;
    logic               wb_regwrite;
    logic [RA_W-1:0]    wb_rd;
    logic [DATA_W-1:0]  wb_data;
    logic               flush;
    logic               ex_stall;
    logic               stall_if;
    logic               ex_valid;
    logic [CTRL_W-1:0]  ex_ctrl;
    logic [RA_W-1:0]    ex_rd;
    logic [RA_W-1:0]    ex_rm;
    logic [RA_W-1:0]    ex_rn;
    logic [DATA_W-1:0]  ex_a;
    logic [DATA_W-1:0]  ex_b;
    logic [DATA_W-1:0]  ex_imm;
    logic [PC_W-1:0]    ex_pc;
    logic [CNT_W-1:0]   stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [11:0] c;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];

    id_stage_hz #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .RA_W    (RA_W),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .resetl      (resetl),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ctrl     (id_ctrl),
        .id_imm      (id_imm),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .ex_stall    (ex_stall),
        .stall_if    (stall_if),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_rd       (ex_rd),
        .ex_rm       (ex_rm),
        .ex_rn       (ex_rn),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_imm      (ex_imm),
        .ex_pc       (ex_pc),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word with rd=[4:0], field [9:5] and field [20:16].
    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] f95,
                                       input logic [4:0] f2016);
        return {11'b0, f2016, 6'b0, f95, rd};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic id_in(input logic v, input logic [31:0] ins, input logic [11:0] c,
                         input logic [63:0] pc);
        id_valid = v;
        id_instr = ins;
        id_ctrl  = c;
        id_pc    = pc;
        id_imm   = pc ^ 64'h5a5a;
    endtask

    task automatic wb_in(input logic en, input logic [4:0] rd, input logic [63:0] d);
        wb_regwrite = en;
        wb_rd       = rd;
        wb_data     = d;
    endtask

    task automatic push_ex(input logic v, input logic [11:0] c, input logic [4:0] rd,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] pc, input bit chk_data);
        exp_t e;
        e.v = v; e.c = c; e.rd = rd; e.a = a; e.b = b; e.pc = pc; e.chk_data = chk_data;
        sb.push_back(e);
    endtask

    // One rising edge, then compare the ID/EX register against the oldest expectation.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, ex_valid, e.v);
            chk({tag, "_ctrl"}, ex_ctrl, e.c);
            if (e.chk_data) begin
                chk({tag, "_rd"}, ex_rd, e.rd);
                chk({tag, "_a"}, ex_a, e.a);
                chk({tag, "_b"}, ex_b, e.b);
                chk({tag, "_pc"}, ex_pc, e.pc);
            end
        end
    endtask

    initial begin
        resetl   = 1'b0;
        flush    = 1'b0;
        ex_stall = 1'b0;
        id_in(1'b0, 32'h0, 12'h0, 64'h0);
        wb_in(1'b0, 5'd0, 64'h0);

        #2;
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_ctrl", ex_ctrl, 12'h0);
        chk("rst_stall_if", stall_if, 1'b0);
        chk("rst_count", stall_count, 2'd0);

        // Write X1=5, then X2=7 with an empty ID slot.
        @(negedge clk);
        resetl = 1'b1;
        wb_in(1'b1, 5'd1, 64'd5);
        push_ex(1'b0, 12'h0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0);
        step("wb_x1");
        @(negedge clk);
        wb_in(1'b1, 5'd2, 64'd7);
        push_ex(1'b0, 12'h0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0);
        step("wb_x2");

        // ADD X3 from X1 and X2.
        @(negedge clk);
        wb_in(1'b0, 5'd0, 64'h0);
        id_in(1'b1, mk(5'd3, 5'd1, 5'd2), C_ADD, 64'h100);
        #1;
        chk("add_stall_if", stall_if, 1'b0);
        push_ex(1'b1, C_ADD, 5'd3, 64'd5, 64'd7, 64'h100, 1'b1);
        step("add");
        chk("add_rm", ex_rm, 5'd1);
        chk("add_rn", ex_rn, 5'd2);
        chk("add_imm", ex_imm, 64'h100 ^ 64'h5a5a);

        // Same-cycle write of X4 is bypassed into the read.
        @(negedge clk);
        wb_in(1'b1, 5'd4, 64'hAB);
        id_in(1'b1, mk(5'd7, 5'd4, 5'd31), C_ADD, 64'h104);
        push_ex(1'b1, C_ADD, 5'd7, 64'hAB, 64'h0, 64'h104, 1'b1);
        step("bypass");

        // Write to X31 is neither bypassed nor stored; X4 now comes from storage.
        @(negedge clk);
        wb_in(1'b1, 5'd31, 64'd9);
        id_in(1'b1, mk(5'd8, 5'd31, 5'd4), C_ADD, 64'h108);
        push_ex(1'b1, C_ADD, 5'd8, 64'h0, 64'hAB, 64'h108, 1'b1);
        step("xzr_bypass");
        @(negedge clk);
        wb_in(1'b0, 5'd0, 64'h0);
        id_in(1'b1, mk(5'd9, 5'd31, 5'd31), C_ADD, 64'h10c);
        push_ex(1'b1, C_ADD, 5'd9, 64'h0, 64'h0, 64'h10c, 1'b1);
        step("xzr_store");

        // LDUR X5,[X1] then dependent ADD X6,X5,X1: one bubble.
        @(negedge clk);
        id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h110);
        #1;
        chk("ld_stall_if", stall_if, 1'b0);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h110, 1'b1);
        step("ldur");
        @(negedge clk);
        id_in(1'b1, mk(5'd6, 5'd5, 5'd1), C_ADD, 64'h114);
        #1;
        chk("hz_stall_if", stall_if, 1'b1);
        push_ex(1'b0, 12'h0, 5'd5, 64'd5, 64'h0, 64'h110, 1'b1);
        step("hz_bubble");
        chk("hz_count", stall_count, 2'd1);
        @(negedge clk);
        #1;
        chk("hz_release", stall_if, 1'b0);
        push_ex(1'b1, C_ADD, 5'd6, 64'h0, 64'd5, 64'h114, 1'b1);
        step("hz_enter");

        // Hazard together with flush: squash, no stall, counter unchanged.
        @(negedge clk);
        id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h118);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h118, 1'b1);
        step("ldur2");
        @(negedge clk);
        id_in(1'b1, mk(5'd6, 5'd5, 5'd1), C_ADD, 64'h11c);
        flush = 1'b1;
        #1;
        chk("flush_stall_if", stall_if, 1'b0);
        push_ex(1'b0, 12'h0, 5'd5, 64'd5, 64'h0, 64'h118, 1'b1);
        step("flush");
        chk("flush_count", stall_count, 2'd1);

        // ex_stall holds every field and raises stall_if.
        @(negedge clk);
        flush = 1'b0;
        id_in(1'b1, mk(5'd3, 5'd1, 5'd2), C_ADD, 64'h120);
        push_ex(1'b1, C_ADD, 5'd3, 64'd5, 64'd7, 64'h120, 1'b1);
        step("pre_hold");
        @(negedge clk);
        ex_stall = 1'b1;
        id_in(1'b1, mk(5'd10, 5'd2, 5'd1), C_ADD, 64'h124);
        #1;
        chk("hold_stall_if", stall_if, 1'b1);
        push_ex(1'b1, C_ADD, 5'd3, 64'd5, 64'd7, 64'h120, 1'b1);
        step("hold");
        chk("hold_rm", ex_rm, 5'd1);

        // ex_stall over a pending hazard: hold, no count; then the bubble counts.
        @(negedge clk);
        ex_stall = 1'b0;
        id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h128);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h128, 1'b1);
        step("ldur3");
        @(negedge clk);
        ex_stall = 1'b1;
        id_in(1'b1, mk(5'd6, 5'd5, 5'd1), C_ADD, 64'h12c);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h128, 1'b1);
        step("hold_hz");
        chk("hold_hz_count", stall_count, 2'd1);
        @(negedge clk);
        ex_stall = 1'b0;
        #1;
        chk("hz2_stall_if", stall_if, 1'b1);
        push_ex(1'b0, 12'h0, 5'd5, 64'd5, 64'h0, 64'h128, 1'b1);
        step("hz2");
        chk("hz2_count", stall_count, 2'd2);

        // Further hazards, alternating rm and rn dependence; counter saturates at 3.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h200 + 64'(k * 8));
            push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h200 + 64'(k * 8), 1'b1);
            step("sat_ld");
            @(negedge clk);
            if (k % 2 == 0) id_in(1'b1, mk(5'd6, 5'd5, 5'd1), C_ADD, 64'h204 + 64'(k * 8));
            else            id_in(1'b1, mk(5'd6, 5'd1, 5'd5), C_ADD, 64'h204 + 64'(k * 8));
            #1;
            chk("sat_stall_if", stall_if, 1'b1);
            push_ex(1'b0, 12'h0, 5'd5, 64'd5, 64'h0, 64'h200 + 64'(k * 8), 1'b1);
            step("sat_bubble");
            chk("sat_count", stall_count, 2'd3);
        end

        // Immediate-form use of the rn field is not a dependency.
        @(negedge clk);
        id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h240);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h240, 1'b1);
        step("ldur_i");
        @(negedge clk);
        id_in(1'b1, mk(5'd6, 5'd1, 5'd5), C_ADDI, 64'h244);
        #1;
        chk("addi_stall_if", stall_if, 1'b0);
        push_ex(1'b1, C_ADDI, 5'd6, 64'd5, 64'h0, 64'h244, 1'b1);
        step("addi");
        chk("addi_count", stall_count, 2'd3);

        // Reset asserted mid-stall clears everything before any edge.
        @(negedge clk);
        id_in(1'b1, mk(5'd5, 5'd1, 5'd0), C_LDUR, 64'h300);
        push_ex(1'b1, C_LDUR, 5'd5, 64'd5, 64'h0, 64'h300, 1'b1);
        step("ldur_r");
        @(negedge clk);
        id_in(1'b1, mk(5'd6, 5'd5, 5'd1), C_ADD, 64'h304);
        #1;
        chk("pre_rst_stall_if", stall_if, 1'b1);
        #1;
        resetl = 1'b0;
        #1;
        chk("mid_rst_valid", ex_valid, 1'b0);
        chk("mid_rst_ctrl", ex_ctrl, 12'h0);
        chk("mid_rst_stall_if", stall_if, 1'b0);
        chk("mid_rst_count", stall_count, 2'd0);

        // First edge after release is a normal advance; registers were cleared.
        @(negedge clk);
        resetl = 1'b1;
        id_in(1'b1, mk(5'd3, 5'd1, 5'd2), C_ADD, 64'h400);
        push_ex(1'b1, C_ADD, 5'd3, 64'h0, 64'h0, 64'h400, 1'b1);
        step("post_rst");
        chk("post_rst_count", stall_count, 2'd0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised ID stage with ID/EX pipeline register.
- Adds what the fixed-width stage lacks:
  - load-use hazard detection with bubble insertion
  - IF/ID stall output
  - flush and downstream-stall inputs
  - valid bit and write-bypassed register file
  - saturating stall counter
- Sits between the IF/ID register and EX. Control decode and sign extension stay in the parent and arrive as inputs.

Parameters:
- DATA_W, 64, register/datapath width
- PC_W, 64, program counter width
- INSTR_W, 32, instruction width
- RA_W, 5, register address width; register count is 2^RA_W, and index 2^RA_W-1 is XZR
- CTRL_W, 12, control bundle width (layout fixed in package)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- resetl  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_instr  in  INSTR_W  instruction
- id_pc  in  PC_W  instruction PC
- id_ctrl  in  CTRL_W  control bundle from Control (reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch, uncondbranch, aluop[3:0])
- id_imm  in  DATA_W  sign-extended immediate
- wb_regwrite  in  1  write-back enable
- wb_rd  in  RA_W  write-back destination
- wb_data  in  DATA_W  write-back data
- flush  in  1  taken branch; squash the ID instruction
- ex_stall  in  1  EX and later stages cannot accept; hold ID/EX
- stall_if  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_ctrl  out  CTRL_W  registered control
- ex_rd, ex_rm, ex_rn  out  RA_W each  registered register addresses (ex_rm/ex_rn for forwarding)
- ex_a, ex_b  out  DATA_W each  registered operands
- ex_imm  out  DATA_W  registered immediate
- ex_pc  out  PC_W  registered PC
- stall_count  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Address fields:
  - rd = instr[4:0]
  - rm = instr[9:5]
  - rn = reg2loc ? instr[4:0] : instr[20:16]
  - Upper bits of these fields are zero-extended when RA_W > 5.
- Register file:
  - Write at rising edge when wb_regwrite and wb_rd != XZR; writes to XZR are ignored.
  - Reads are combinational and always return 0 for XZR.
  - Same-cycle bypass: if wb_regwrite, wb_rd == read address, and the address != XZR, the read returns wb_data.
  - Reset clears all registers.
- Operand use:
  - rm is used unless uncondbranch.
  - rn is used iff !uncondbranch and (reg2loc or !alusrc).
- Hazard (combinational) is true when all of: id_valid, ex_valid, ex_ctrl.memread, ex_rd != XZR, and ex_rd equals a used source address.
- Per-cycle priority, evaluated at the rising edge:
  1. flush: ex_valid<=0, ex_ctrl<=0; data fields hold; stall_if=0.
  2. ex_stall: all ID/EX fields hold; stall_if=1.
  3. hazard: bubble (ex_valid<=0, ex_ctrl<=0, data hold); stall_if=1; stall_count increments.
  4. normal: load all fields from ID; ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0.
- stall_if = !flush and (ex_stall or hazard).
  - flush overrides a pending hazard, because the instruction is being squashed.
- stall_count:
  - Saturating at all ones; no wrap.
  - Increments only on case 3, never under flush or ex_stall.
- Latency: one cycle from ID to EX outputs. A hazard adds exactly one bubble, because the load leaves EX next cycle.
- Reset:
  - Asynchronous and immediate, including mid-stall.
  - All registered outputs and stall_count go to 0, so stall_if=0.
  - After release, the first rising edge behaves as normal.
- Simultaneous write-back to a register read in ID: ID sees the new value via the bypass.

Decomposition:
- Package id_pkg:
  - bit indices of the id_ctrl fields
  - CTRL_W
  - function xzr(RA_W)
  - field positions RD_LSB, RM_LSB, RN_LSB
- Sub-module regfile_bypass (parameters DATA_W, RA_W): two read ports, one write port, async active-low reset, XZR and bypass rules as above.

Test Plan:
1. Reset mid-operation: drive resetl=0 with ex_valid=1 → ex_valid=0, ex_ctrl=0, stall_if=0, stall_count=0 immediately, before any clock edge.
2. Normal flow: write X1=5 and X2=7 via WB, then ADD X3,X1,X2 in ID → next cycle ex_a=5, ex_b=7, ex_rd=3, ex_valid=1.
3. Bypass: wb writes X4=0xAB in the same cycle as ID reads X4 → ex_a=0xAB. A read of X31 → 0 even after wb_rd=31, wb_data=9.
4. Load-use: LDUR X5 in EX, then ADD X6,X5,X1 in ID → stall_if=1 for one cycle, bubble with ex_valid=0, stall_count=1. The ADD enters EX on the following cycle.
5. Priority: hazard and flush asserted together → stall_if=0, bubble, stall_count unchanged. With ex_stall=1, ID/EX holds its prior values and stall_if=1.
6. Saturation: CNT_W=2 and four consecutive hazards → stall_count=3 and stays at 3.
